// File: rtl/reg_readout_pkg.sv
// Shared types and constants for the register readout transmitter.
// Optional feature macro: REG_READOUT_PARITY_EN (adds an even-parity bit per frame).
package reg_readout_pkg;

  // Transmitter states; PARITY_BIT exists only in the parity build.
  typedef enum logic [2:0] {
    IDLE,
    START_BIT,
    DATA_BITS,
`ifdef REG_READOUT_PARITY_EN
    PARITY_BIT,
`endif
    STOP_BIT
  } state_t;

  localparam int FRAME_BYTES   = 4;
  localparam int BITS_PER_BYTE = 8;
  localparam int BYTE_IDX_W    = 2;
  localparam int BIT_IDX_W     = 3;
  localparam int WORD_W        = FRAME_BYTES * BITS_PER_BYTE;

  localparam logic [BYTE_IDX_W-1:0] LAST_BYTE = BYTE_IDX_W'(FRAME_BYTES - 1);
  localparam logic [BIT_IDX_W-1:0]  LAST_BIT  = BIT_IDX_W'(BITS_PER_BYTE - 1);

endpackage

// File: rtl/reg_readout_tx_if.sv
// Host-side bus of the register readout transmitter.
// Optional feature macro: REG_READOUT_PARITY_EN (affects only the state encoding).
//
// Handshake: the host raises start with data_readReg valid; the word is taken
// on a rising edge where the transmitter is idle (busy low). busy acts as an
// inverted ready: while it is high, start is ignored and nothing is queued.
// done pulses for one cycle when the last stop bit ends; busy is already low
// in that cycle, so a start held high there launches the next word at once.
// state is a debug view of the transmitter FSM.
interface reg_readout_tx_if;
  import reg_readout_pkg::*;

  logic              start;
  logic [WORD_W-1:0] data_readReg;
  logic              tx;
  logic              busy;
  logic              done;
  state_t            state;

  modport master (output start, data_readReg, input tx, busy, done, state);
  modport slave  (input start, data_readReg, output tx, busy, done, state);

endinterface

// File: rtl/reg_readout_tx_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and ticks for one cycle on the
// last count of each bit period. Cleared when a word is accepted.
// Optional feature macro: REG_READOUT_PARITY_EN (not used here).
module reg_readout_tx_bit_timer #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count;

  assign tick = en && !clear && (count == LAST);

  // Free-running wrap counter while enabled, restarted on clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= (count == LAST) ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/reg_readout_tx.sv
// Register readout transmitter: snapshots a 32-bit register on start and sends
// it as four UART frames, least-significant byte first, LSB first in a byte.
// Optional feature macro: REG_READOUT_PARITY_EN (8E1 frames instead of 8N1).
module reg_readout_tx
  import reg_readout_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic             clk,
  input  logic             reset,
  reg_readout_tx_if.slave  bus
);

  state_t                state;
  logic [WORD_W-1:0]     shift_buf;
  logic [BYTE_IDX_W-1:0] byte_cnt;
  logic [BIT_IDX_W-1:0]  bit_cnt;
  logic                  tx_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  accept;
  logic                  tick;
`ifdef REG_READOUT_PARITY_EN
  logic                  parity_acc;
`endif

  // A word is taken only while idle; start at any other time is dropped.
  assign accept = (state == IDLE) && bus.start;

  reg_readout_tx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk   (clk),
    .reset (reset),
    .clear (accept),
    .en    (state != IDLE),
    .tick  (tick)
  );

  // Transmit FSM; tx/busy/done are registered and set on the transition edge
  // so the line changes exactly at bit-period boundaries.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      shift_buf  <= '0;
      byte_cnt   <= '0;
      bit_cnt    <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef REG_READOUT_PARITY_EN
      parity_acc <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          if (bus.start) begin
            shift_buf <= bus.data_readReg;
            byte_cnt  <= '0;
            bit_cnt   <= '0;
            tx_q      <= 1'b0;
            busy_q    <= 1'b1;
            state     <= START_BIT;
          end
        end

        START_BIT: begin
          if (tick) begin
            tx_q    <= shift_buf[0];
            bit_cnt <= '0;
`ifdef REG_READOUT_PARITY_EN
            parity_acc <= 1'b0;
`endif
            state   <= DATA_BITS;
          end
        end

        DATA_BITS: begin
          if (tick) begin
            // Shift on every data bit, including the last, so the next byte
            // lands in the low bits ready for its frame.
            shift_buf <= shift_buf >> 1;
`ifdef REG_READOUT_PARITY_EN
            parity_acc <= parity_acc ^ shift_buf[0];
`endif
            if (bit_cnt == LAST_BIT) begin
`ifdef REG_READOUT_PARITY_EN
              tx_q  <= parity_acc ^ shift_buf[0];
              state <= PARITY_BIT;
`else
              tx_q  <= 1'b1;
              state <= STOP_BIT;
`endif
            end else begin
              bit_cnt <= bit_cnt + BIT_IDX_W'(1);
              tx_q    <= shift_buf[1];
            end
          end
        end

`ifdef REG_READOUT_PARITY_EN
        PARITY_BIT: begin
          if (tick) begin
            tx_q  <= 1'b1;
            state <= STOP_BIT;
          end
        end
`endif

        STOP_BIT: begin
          if (tick) begin
            if (byte_cnt == LAST_BYTE) begin
              tx_q   <= 1'b1;
              busy_q <= 1'b0;
              done_q <= 1'b1;
              state  <= IDLE;
            end else begin
              byte_cnt <= byte_cnt + BYTE_IDX_W'(1);
              bit_cnt  <= '0;
              tx_q     <= 1'b0;
              state    <= START_BIT;
            end
          end
        end

        default: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.tx    = tx_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.state = state;

endmodule

// File: tb/tb_reg_readout_tx.sv
// Testbench for reg_readout_tx: per-cycle comparison against a queue-based
// line model, plus literal checks on decoded bytes and word latency.
// Optional feature macro: REG_READOUT_PARITY_EN (bench follows the same build).
module tb_reg_readout_tx;
  import reg_readout_pkg::*;

  localparam int CPB = 4;
`ifdef REG_READOUT_PARITY_EN
  localparam int FRAME_BITS  = 11;
  localparam int LIT_LATENCY = 176;
`else
  localparam int FRAME_BITS  = 10;
  localparam int LIT_LATENCY = 160;
`endif
  localparam int WORD_CYCLES = FRAME_BYTES * FRAME_BITS * CPB;
  localparam int LOG_N       = 16384;
  localparam logic [2:0] IDLE_OUT = 3'b100;  // {tx, busy, done}

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  reg_readout_tx_if bus ();

  reg_readout_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [2:0] exp_q[$];
  logic [2:0] cur = IDLE_OUT;
  logic tx_log[LOG_N];
  int word_start_cyc = 0;
  int done_cyc = 0;
  int done_count = 0;
  logic prev_busy = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Model: one line level per bit-period cycle, busy high throughout, then a done cycle.
  task automatic push_bit(input logic v);
    repeat (CPB) exp_q.push_back({v, 1'b1, 1'b0});
  endtask

  task automatic push_word(input logic [31:0] w);
    logic [7:0] by;
    for (int b = 0; b < FRAME_BYTES; b++) begin
      by = w[8*b +: 8];
      push_bit(1'b0);
      for (int i = 0; i < 8; i++) push_bit(by[i]);
`ifdef REG_READOUT_PARITY_EN
      push_bit(^by);
`endif
      push_bit(1'b1);
    end
    exp_q.push_back(3'b101);
  endtask

  // Model update on each edge, compare 1 time unit later.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (reset) begin
        exp_q.delete();
        cur = IDLE_OUT;
      end else begin
        if (!cur[1] && bus.start) push_word(bus.data_readReg);
        cur = (exp_q.size() > 0) ? exp_q.pop_front() : IDLE_OUT;
      end
      #1;
      check("outputs{tx,busy,done}", {29'd0, bus.tx, bus.busy, bus.done}, {29'd0, cur});
      tx_log[cyc % LOG_N] = bus.tx;
      if (bus.busy && !prev_busy) word_start_cyc = cyc;
      if (bus.done) begin
        done_cyc = cyc;
        done_count++;
      end
      prev_busy = bus.busy;
    end
  end

  // ---------------- helpers ----------------
  function automatic logic [7:0] decode_byte(input int t0, input int k);
    logic [7:0] r;
    for (int i = 0; i < 8; i++)
      r[i] = tx_log[(t0 + k*FRAME_BITS*CPB + (1+i)*CPB + CPB/2) % LOG_N];
    return r;
  endfunction

  function automatic logic decode_parity(input int t0, input int k);
    return tx_log[(t0 + k*FRAME_BITS*CPB + 9*CPB + CPB/2) % LOG_N];
  endfunction

  task automatic check_word(input string name, input int t0, input logic [31:0] w);
    for (int k = 0; k < FRAME_BYTES; k++) begin
      check(name, {24'd0, decode_byte(t0, k)}, {24'd0, w[8*k +: 8]});
`ifdef REG_READOUT_PARITY_EN
      check({name, "_parity"}, {31'd0, decode_parity(t0, k)}, {31'd0, ^w[8*k +: 8]});
`endif
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_word(input logic [31:0] w);
    bus.data_readReg = w;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int n0 = done_count;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_count != n0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL wait_done: no done pulse within %0d cycles", budget);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    bit ok;
    logic [31:0] w;
    int n, first_start, first_done;
    logic [7:0] lit_bytes[4];

    bus.start = 1'b0;
    bus.data_readReg = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    #1;
    check("reset_tx",    {31'd0, bus.tx},   32'd1);
    check("reset_busy",  {31'd0, bus.busy}, 32'd0);
    check("reset_done",  {31'd0, bus.done}, 32'd0);
    check("reset_state", {29'd0, bus.state}, {29'd0, IDLE});
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Single word with literal byte order and latency.
    send_word(32'hA5C3_0F81);
    wait_done(WORD_CYCLES + 20, ok);
    check("single_latency", done_cyc - word_start_cyc, LIT_LATENCY);
    lit_bytes = '{8'h81, 8'h0F, 8'hC3, 8'hA5};
    for (int k = 0; k < 4; k++)
      check("single_byte", {24'd0, decode_byte(word_start_cyc, k)}, {24'd0, lit_bytes[k]});
    repeat (3) @(negedge clk);

    // Start while busy is ignored.
    n = done_count;
    send_word(32'h0000_0000);
    repeat (48) @(negedge clk);
    send_word(32'hFFFF_FFFF);
    wait_done(WORD_CYCLES + 20, ok);
    check_word("busy_ignore_byte", word_start_cyc, 32'h0000_0000);
    repeat (3 * CPB) @(negedge clk);
    check("busy_ignore_done_count", done_count - n, 1);

    // Back-to-back with start held across done.
    n = done_count;
    bus.data_readReg = 32'h1234_5678;
    bus.start = 1'b1;
    @(negedge clk);
    bus.data_readReg = 32'h9ABC_DEF0;
    wait_done(WORD_CYCLES + 20, ok);
    first_start = word_start_cyc;
    first_done = done_cyc;
    @(negedge clk);
    bus.start = 1'b0;
    check("b2b_restart_cycle", word_start_cyc, first_done + 1);
    wait_done(WORD_CYCLES + 20, ok);
    check("b2b_done_count", done_count - n, 2);
    lit_bytes = '{8'h78, 8'h56, 8'h34, 8'h12};
    for (int k = 0; k < 4; k++)
      check("b2b_first_byte", {24'd0, decode_byte(first_start, k)}, {24'd0, lit_bytes[k]});
    lit_bytes = '{8'hF0, 8'hDE, 8'hBC, 8'h9A};
    for (int k = 0; k < 4; k++)
      check("b2b_second_byte", {24'd0, decode_byte(word_start_cyc, k)}, {24'd0, lit_bytes[k]});
    repeat (3) @(negedge clk);

    // Reset in byte 2, data bit 3.
    n = done_count;
    send_word($urandom);
    repeat (2*FRAME_BITS*CPB + 4*CPB) @(negedge clk);
    check("midframe_busy_before", {31'd0, bus.busy}, 32'd1);
    reset = 1'b1;
    #1;
    check("midframe_reset_tx",   {31'd0, bus.tx},   32'd1);
    check("midframe_reset_busy", {31'd0, bus.busy}, 32'd0);
    check("midframe_reset_done", {31'd0, bus.done}, 32'd0);
    repeat (3) begin
      @(negedge clk);
      check("midframe_hold", {29'd0, bus.tx, bus.busy, bus.done}, {29'd0, IDLE_OUT});
    end
    reset = 1'b0;
    repeat (2 * CPB) @(negedge clk);
    check("midframe_no_done", done_count - n, 0);
    w = $urandom;
    send_word(w);
    wait_done(WORD_CYCLES + 20, ok);
    check_word("midframe_fresh_byte", word_start_cyc, w);
    repeat (2) @(negedge clk);

`ifdef REG_READOUT_PARITY_EN
    // Parity literals.
    send_word(32'h0000_0007);
    wait_done(WORD_CYCLES + 20, ok);
    check("parity_latency", done_cyc - word_start_cyc, 176);
    check("parity_byte0", {31'd0, decode_parity(word_start_cyc, 0)}, 32'd1);
    for (int k = 1; k < 4; k++)
      check("parity_zero_byte", {31'd0, decode_parity(word_start_cyc, k)}, 32'd0);
    repeat (2) @(negedge clk);
`endif

    // Random words, random stray starts and data churn after capture.
    for (int it = 0; it < 10; it++) begin
      w = $urandom;
      send_word(w);
      repeat ($urandom_range(1, 60)) begin
        @(negedge clk);
        bus.data_readReg = $urandom;
      end
      if ($urandom_range(0, 1) == 1) begin
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
      end
      wait_done(WORD_CYCLES + 20, ok);
      check("rand_latency", done_cyc - word_start_cyc, WORD_CYCLES);
      check_word("rand_byte", word_start_cyc, w);
      repeat ($urandom_range(0, 5)) @(negedge clk);
    end

    repeat (2 * CPB) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
